// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: owner codes, FSM states
// and the data width used on every requester and memory port.
package bk_mem_pkg;

    localparam int DW = 16;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_DSK  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the
// arbiter's view, master is the surrounding requesters plus memory.
interface mem_arbiter_if
    import bk_mem_pkg::*;
#(
    parameter int AW = 25
);

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;

    logic          dsk_req;
    logic [AW-1:0] dsk_addr;
    logic          dsk_we;
    logic [DW-1:0] dsk_din;
    logic          dsk_ack;

    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [1:0]    cpu_be;
    logic [DW-1:0] cpu_din;
    logic          cpu_ack;

    logic [DW-1:0] rd_data;
    logic [1:0]    owner;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [1:0]    mem_be;
    logic          mem_we;
    logic          mem_rd;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  vid_req, vid_addr,
        input  dsk_req, dsk_addr, dsk_we, dsk_din,
        input  cpu_req, cpu_addr, cpu_we, cpu_be, cpu_din,
        input  mem_dout,
        output vid_ack, dsk_ack, cpu_ack, rd_data, owner,
        output mem_addr, mem_din, mem_be, mem_we, mem_rd
    );

    modport master (
        output vid_req, vid_addr,
        output dsk_req, dsk_addr, dsk_we, dsk_din,
        output cpu_req, cpu_addr, cpu_we, cpu_be, cpu_din,
        output mem_dout,
        input  vid_ack, dsk_ack, cpu_ack, rd_data, owner,
        input  mem_addr, mem_din, mem_be, mem_we, mem_rd
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: video first, then a starved CPU,
// then disk, then CPU.
module mem_arb_pick
    import bk_mem_pkg::*;
(
    input  logic       i_vid_req,
    input  logic       i_dsk_req,
    input  logic       i_cpu_req,
    input  logic       i_starve,
    output logic [1:0] o_owner
);

    always_comb begin
        o_owner = OWN_NONE;
        if (i_vid_req)
            o_owner = OWN_VID;
        else if (i_starve && i_cpu_req)
            o_owner = OWN_CPU;
        else if (i_dsk_req)
            o_owner = OWN_DSK;
        else if (i_cpu_req)
            o_owner = OWN_CPU;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences one access at a time from video, disk DMA and CPU onto a
// fixed-latency memory port, with a CPU starvation guard.
module mem_arbiter
    import bk_mem_pkg::*;
#(
    parameter int AW         = 25,
    parameter int RD_LAT     = 2,
    parameter int CPU_STARVE = 8
) (
    input  logic         clk_sys,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [1:0]    r_owner;
    logic [1:0]    w_pick;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [1:0]    r_be;
    logic [DW-1:0] r_din;
    logic [DW-1:0] r_rd_data;
    logic [3:0]    r_lat;
    logic [7:0]    r_starve;
    logic          w_starve;
    logic          w_last;

    assign w_starve = (r_starve == 8'(CPU_STARVE));
    assign w_last   = (r_lat == 4'd0);

    mem_arb_pick u_pick (
        .i_vid_req (bus.vid_req),
        .i_dsk_req (bus.dsk_req),
        .i_cpu_req (bus.cpu_req),
        .i_starve  (w_starve),
        .o_owner   (w_pick)
    );

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.mem_we   = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.vid_ack  = 1'b0;
        bus.dsk_ack  = 1'b0;
        bus.cpu_ack  = 1'b0;
        bus.mem_addr = r_addr;
        bus.mem_din  = r_din;
        bus.mem_be   = r_be;
        bus.rd_data  = r_rd_data;
        bus.owner    = r_owner;
        unique case (r_state)
            IDLE: begin
                if (w_pick != OWN_NONE)
                    w_next = ISSUE;
            end
            ISSUE: begin
                bus.mem_we = r_we;
                bus.mem_rd = !r_we;
                w_next     = r_we ? DONE : WAIT;
            end
            WAIT: begin
                if (w_last)
                    w_next = DONE;
            end
            DONE: begin
                bus.vid_ack = (r_owner == OWN_VID);
                bus.dsk_ack = (r_owner == OWN_DSK);
                bus.cpu_ack = (r_owner == OWN_CPU);
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_owner   <= OWN_NONE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= 2'b00;
            r_din     <= '0;
            r_rd_data <= '0;
            r_lat     <= 4'd0;
            r_starve  <= 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Only a disk win over a waiting CPU counts toward starvation
                    if (!bus.cpu_req || w_pick == OWN_CPU)
                        r_starve <= 8'd0;
                    else if (w_pick == OWN_DSK && !w_starve)
                        r_starve <= r_starve + 8'd1;
                    r_owner <= w_pick;
                    unique case (w_pick)
                        OWN_VID: begin
                            r_addr <= bus.vid_addr;
                            r_we   <= 1'b0;
                            r_be   <= 2'b11;
                            r_din  <= '0;
                        end
                        OWN_DSK: begin
                            r_addr <= bus.dsk_addr;
                            r_we   <= bus.dsk_we;
                            r_be   <= 2'b11;
                            r_din  <= bus.dsk_din;
                        end
                        OWN_CPU: begin
                            r_addr <= bus.cpu_addr;
                            r_we   <= bus.cpu_we;
                            r_be   <= bus.cpu_be;
                            r_din  <= bus.cpu_din;
                        end
                        default: ;
                    endcase
                end
                ISSUE: r_lat <= 4'(RD_LAT - 1);
                WAIT: begin
                    if (w_last)
                        r_rd_data <= bus.mem_dout;
                    else
                        r_lat <= r_lat - 4'd1;
                end
                DONE: r_owner <= OWN_NONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized run against a schedule-level reference model.
module tb_mem_arbiter;
    import bk_mem_pkg::*;

    localparam int AW     = 25;
    localparam int RD_LAT = 2;
    localparam int CS     = 4;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .CPU_STARVE(CS)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] smem [logic [AW-1:0]];
    logic [15:0] gmem [logic [AW-1:0]];

    function automatic logic [15:0] dflt(logic [AW-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] srd(logic [AW-1:0] a);
        return smem.exists(a) ? smem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] grd(logic [AW-1:0] a);
        return gmem.exists(a) ? gmem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] merge(logic [15:0] o, logic [15:0] n,
                                          logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    // Fixed-latency memory: data valid RD_LAT cycles after mem_rd, noise otherwise
    int          rd_left = 0;
    logic [15:0] rd_word = '0;
    always begin
        @(negedge clk_sys);
        if (bus.mem_we === 1'b1)
            smem[bus.mem_addr] = merge(srd(bus.mem_addr), bus.mem_din, bus.mem_be);
        if (bus.mem_rd === 1'b1) begin
            rd_left = RD_LAT;
            rd_word = srd(bus.mem_addr);
        end
        @(posedge clk_sys);
        #1;
        if (rd_left > 0) begin
            rd_left--;
            bus.mem_dout = (rd_left == 0) ? rd_word : 16'($urandom);
        end else begin
            bus.mem_dout = 16'($urandom);
        end
    end

    typedef struct packed {
        logic [2:0]    ack;
        logic          we;
        logic          rd;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    be;
        logic [1:0]    own;
        logic [15:0]   rdat;
    } obs_t;

    obs_t ob [0:63];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vid_req  = 1'b0;
        bus.vid_addr = '0;
        bus.dsk_req  = 1'b0;
        bus.dsk_addr = '0;
        bus.dsk_we   = 1'b0;
        bus.dsk_din  = '0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b00;
        bus.cpu_din  = '0;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (3) tick();
    endtask

    // Records n cycles; a requester drops req on its ack unless held
    task automatic observe(int n, logic [2:0] hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            ob[i] = {bus.vid_ack, bus.dsk_ack, bus.cpu_ack, bus.mem_we,
                     bus.mem_rd, bus.mem_addr, bus.mem_din, bus.mem_be,
                     bus.owner, bus.rd_data};
            tick();
            if (ob[i].ack[2] && !hold[2]) bus.vid_req = 1'b0;
            if (ob[i].ack[1] && !hold[1]) bus.dsk_req = 1'b0;
            if (ob[i].ack[0] && !hold[0]) bus.cpu_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk_sys);
        n_run++;
        if ({bus.vid_ack, bus.dsk_ack, bus.cpu_ack, bus.mem_we, bus.mem_rd} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {bus.vid_ack, bus.dsk_ack, bus.cpu_ack, bus.mem_we, bus.mem_rd});
        end
        n_run++;
        if ({bus.owner, bus.mem_addr, bus.mem_din, bus.mem_be, bus.rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: own=%0d addr=%h din=%h be=%b rd=%h want all 0",
                     bus.owner, bus.mem_addr, bus.mem_din, bus.mem_be, bus.rd_data);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_cpu_write();
        settle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 25'h00100;
        bus.cpu_we   = 1'b1;
        bus.cpu_be   = 2'b11;
        bus.cpu_din  = 16'h1234;
        observe(5, 3'b000);
        n_run++;
        if ({ob[1].we, ob[1].rd, ob[1].addr, ob[1].din, ob[1].be} !==
            {2'b10, 25'h00100, 16'h1234, 2'b11}) begin
            n_fail++;
            $display("FAIL wr_issue: we=%b rd=%b addr=%h din=%h be=%b want 1 0 00100 1234 11",
                     ob[1].we, ob[1].rd, ob[1].addr, ob[1].din, ob[1].be);
        end
        n_run++;
        if (ob[2].ack !== 3'b001 || ob[1].ack !== 3'b000 || ob[3].ack !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_ack: c1=%b c2=%b c3=%b want 000 001 000",
                     ob[1].ack, ob[2].ack, ob[3].ack);
        end
        n_run++;
        if ({ob[0].own, ob[1].own, ob[2].own, ob[3].own} !== {OWN_NONE, OWN_CPU, OWN_CPU, OWN_NONE}) begin
            n_fail++;
            $display("FAIL wr_owner: got %0d %0d %0d %0d want 0 3 3 0",
                     ob[0].own, ob[1].own, ob[2].own, ob[3].own);
        end
    endtask

    task automatic test_cpu_read();
        int acks;
        settle();
        smem[25'h00200] = 16'hBEEF;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 25'h00200;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b11;
        observe(7, 3'b000);
        n_run++;
        if (ob[1].rd !== 1'b1 || ob[1].we !== 1'b0 || ob[1].addr !== 25'h00200) begin
            n_fail++;
            $display("FAIL rd_issue: rd=%b we=%b addr=%h want 1 0 00200",
                     ob[1].rd, ob[1].we, ob[1].addr);
        end
        n_run++;
        if (ob[4].ack !== 3'b001 || ob[4].rdat !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_ack: ack=%b data=%h want 001 beef", ob[4].ack, ob[4].rdat);
        end
        acks = 0;
        for (int i = 0; i < 7; i++)
            acks += ob[i].ack[2] + ob[i].ack[1] + ob[i].ack[0];
        n_run++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL rd_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_simultaneous();
        int          at [3];
        logic [15:0] dv [3];
        int          want [3];
        settle();
        smem[25'h00300] = 16'h1111;
        smem[25'h00301] = 16'h2222;
        smem[25'h00302] = 16'h3333;
        want = '{4, 9, 14};
        bus.vid_req  = 1'b1;
        bus.vid_addr = 25'h00300;
        bus.dsk_req  = 1'b1;
        bus.dsk_addr = 25'h00301;
        bus.dsk_we   = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 25'h00302;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b11;
        observe(17, 3'b000);
        at = '{-1, -1, -1};
        dv = '{16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 17; i++)
            for (int k = 0; k < 3; k++)
                if (ob[i].ack[2-k] && at[k] < 0) begin
                    at[k] = i;
                    dv[k] = ob[i].rdat;
                end
        for (int k = 0; k < 3; k++) begin
            n_run++;
            if (at[k] != want[k] || dv[k] !== 16'(16'h1111 * (k + 1))) begin
                n_fail++;
                $display("FAIL simul_req%0d: ack cycle %0d data %h want cycle %0d data %h",
                         k, at[k], dv[k], want[k], 16'(16'h1111 * (k + 1)));
            end
        end
    endtask

    task automatic test_starvation();
        int q [$];
        int got;
        int want [10];
        settle();
        want = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
        bus.dsk_req  = 1'b1;
        bus.dsk_addr = 25'h00400;
        bus.dsk_we   = 1'b1;
        bus.dsk_din  = 16'hAAAA;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 25'h00401;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b11;
        observe(36, 3'b011);
        for (int i = 0; i < 36; i++) begin
            if (ob[i].ack[1]) q.push_back(2);
            if (ob[i].ack[0]) q.push_back(3);
        end
        for (int i = 0; i < 10; i++) begin
            got = (i < q.size()) ? q[i] : -1;
            n_run++;
            if (got != want[i]) begin
                n_fail++;
                $display("FAIL starve_seq[%0d]: got owner %0d want %0d", i, got, want[i]);
            end
        end
        n_run++;
        if (ob[16].ack !== 3'b001 || ob[33].ack !== 3'b001) begin
            n_fail++;
            $display("FAIL starve_cpu_ack: c16=%b c33=%b want 001 001",
                     ob[16].ack, ob[33].ack);
        end
    endtask

    task automatic test_reset_abort();
        settle();
        bus.dsk_req  = 1'b1;
        bus.dsk_addr = 25'h00500;
        bus.dsk_we   = 1'b0;
        tick();
        tick();
        reset       = 1'b1;
        bus.dsk_req = 1'b0;
        tick();
        reset = 1'b0;
        observe(6, 3'b000);
        for (int i = 0; i < 6; i++) begin
            n_run++;
            if (ob[i].ack !== 3'b000 ||
                {ob[i].we, ob[i].rd, ob[i].addr, ob[i].din, ob[i].be, ob[i].own, ob[i].rdat} !== '0) begin
                n_fail++;
                $display("FAIL abort_c%0d: ack=%b we=%b rd=%b addr=%h own=%0d rd=%h want all 0",
                         i, ob[i].ack, ob[i].we, ob[i].rd, ob[i].addr, ob[i].own, ob[i].rdat);
            end
        end
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 25'h00510;
        bus.cpu_we   = 1'b1;
        bus.cpu_be   = 2'b11;
        bus.cpu_din  = 16'h5151;
        observe(4, 3'b000);
        n_run++;
        if (ob[1].we !== 1'b1 || ob[2].ack !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_cpu_wr: we=%b ack=%b want 1 001", ob[1].we, ob[2].ack);
        end
    endtask

    task automatic test_be_zero();
        settle();
        smem[25'h00600] = 16'hC0DE;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 25'h00600;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b11;
        observe(6, 3'b000);
        n_run++;
        if (ob[4].rdat !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL be0_pre_read: got %h want c0de", ob[4].rdat);
        end
        tick();
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        bus.cpu_be  = 2'b00;
        bus.cpu_din = 16'hFFFF;
        observe(4, 3'b000);
        n_run++;
        if (ob[1].we !== 1'b1 || ob[1].be !== 2'b00 || ob[2].ack !== 3'b001) begin
            n_fail++;
            $display("FAIL be0_write: we=%b be=%b ack=%b want 1 00 001",
                     ob[1].we, ob[1].be, ob[2].ack);
        end
        n_run++;
        if (ob[0].rdat !== 16'hC0DE || ob[3].rdat !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL be0_rd_hold: got %h %h want c0de", ob[0].rdat, ob[3].rdat);
        end
    endtask

    // Reference: arbiter free at 'free'; each grant lasts a fixed span
    task automatic test_random(int ncyc);
        logic [AW-1:0] a [3];
        logic          w [3];
        logic [1:0]    b [3];
        logic [15:0]   d [3];
        bit            act [3];
        bit            nw;
        logic [AW-1:0] ga;
        logic          gw;
        logic [1:0]    gb;
        logic [15:0]   gd;
        logic [15:0]   exp_rdat;
        logic [2:0]    exp_ack;
        logic [1:0]    exp_own;
        int            own, g, ack_at, free, sc, pick;
        own = -1; g = -10; ack_at = -10; free = 0; sc = 0;
        ga = '0; gw = 1'b0; gb = 2'b00; gd = '0; exp_rdat = '0;
        for (int k = 0; k < 3; k++) begin
            act[k] = 1'b0; a[k] = '0; w[k] = 1'b0; b[k] = 2'b11; d[k] = '0;
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk_sys);
            if (t >= free) begin
                pick = -1;
                if (act[0]) pick = 0;
                else if (sc == CS && act[2]) pick = 2;
                else if (act[1]) pick = 1;
                else if (act[2]) pick = 2;
                if (!act[2] || pick == 2) sc = 0;
                else if (pick == 1 && sc < CS) sc++;
                if (pick >= 0) begin
                    own = pick; g = t;
                    ga = a[pick]; gw = w[pick]; gb = b[pick]; gd = d[pick];
                    ack_at = t + (gw ? 2 : RD_LAT + 2);
                    free = ack_at + 1;
                end else begin
                    free = t + 1;
                end
            end
            exp_ack = (t == ack_at) ? 3'(3'b100 >> own) : 3'b000;
            exp_own = (t > g && t <= ack_at) ? 2'(own + 1) : OWN_NONE;
            if (t == ack_at && !gw) exp_rdat = grd(ga);
            n_run++;
            if ({bus.vid_ack, bus.dsk_ack, bus.cpu_ack} !== exp_ack) begin
                n_fail++;
                $display("FAIL rnd_ack t=%0d: got %b want %b", t,
                         {bus.vid_ack, bus.dsk_ack, bus.cpu_ack}, exp_ack);
            end
            n_run++;
            if (bus.owner !== exp_own) begin
                n_fail++;
                $display("FAIL rnd_owner t=%0d: got %0d want %0d", t, bus.owner, exp_own);
            end
            n_run++;
            if ({bus.mem_we, bus.mem_rd} !== {t == g + 1 && gw, t == g + 1 && !gw}) begin
                n_fail++;
                $display("FAIL rnd_strobe t=%0d: got we=%b rd=%b want we=%b rd=%b", t,
                         bus.mem_we, bus.mem_rd, t == g + 1 && gw, t == g + 1 && !gw);
            end
            if (t == g + 1) begin
                n_run++;
                if (bus.mem_addr !== ga || bus.mem_be !== gb || (gw && bus.mem_din !== gd)) begin
                    n_fail++;
                    $display("FAIL rnd_issue t=%0d: addr=%h be=%b din=%h want %h %b %h", t,
                             bus.mem_addr, bus.mem_be, bus.mem_din, ga, gb, gd);
                end
            end
            n_run++;
            if (bus.rd_data !== exp_rdat) begin
                n_fail++;
                $display("FAIL rnd_rdata t=%0d: got %h want %h", t, bus.rd_data, exp_rdat);
            end
            if (t == ack_at && gw) gmem[ga] = merge(grd(ga), gd, gb);
            tick();
            for (int k = 0; k < 3; k++) begin
                nw = 1'b0;
                if (act[k] && own == k && t == ack_at) begin
                    nw = ($urandom_range(0, 2) == 0);
                    act[k] = nw;
                end else if (!act[k]) begin
                    nw = ($urandom_range(0, 3) == 0);
                    act[k] = nw;
                end
                if (nw) begin
                    a[k] = 25'h1F0000 + 25'($urandom_range(0, 7));
                    w[k] = (k == 0) ? 1'b0 : 1'($urandom);
                    b[k] = (k == 2) ? 2'($urandom) : 2'b11;
                    d[k] = 16'($urandom);
                end
            end
            bus.vid_req  = act[0];
            bus.vid_addr = a[0];
            bus.dsk_req  = act[1];
            bus.dsk_addr = a[1];
            bus.dsk_we   = w[1];
            bus.dsk_din  = d[1];
            bus.cpu_req  = act[2];
            bus.cpu_addr = a[2];
            bus.cpu_we   = w[2];
            bus.cpu_be   = b[2];
            bus.cpu_din  = d[2];
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_reset_abort();
        test_be_zero();
        test_random(800);
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single shared main-memory port between three requesters: video fetch (read-only), disk DMA copy engine, and CPU bus.
It sits between the memory back end and the video, disk and CPU-side bus logic, and sequences one access at a time against a fixed-latency memory.
Fixed priority is video > disk > CPU. A starvation counter guarantees CPU progress during long disk copies.

Parameters:
AW, 25, address width (word address) on all requester and memory ports
RD_LAT, 2, memory read latency in clk_sys cycles from mem_rd pulse to valid mem_dout; legal range 1..15
CPU_STARVE, 8, consecutive disk grants allowed while cpu_req is pending before the CPU wins over disk; legal range 1..255

Ports:
clk_sys  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
vid_req  in  1  video read request, level, held until vid_ack
vid_addr  in  AW  video read address
vid_ack  out  1  one-cycle pulse; rd_data valid in the same cycle
dsk_req  in  1  disk DMA request, level
dsk_addr  in  AW  disk address
dsk_we  in  1  disk write (1) / read (0)
dsk_din  in  16  disk write data
dsk_ack  out  1  one-cycle completion pulse
cpu_req  in  1  CPU request, level
cpu_addr  in  AW  CPU address
cpu_we  in  1  CPU write (1) / read (0)
cpu_be  in  2  CPU byte enables (wtbt)
cpu_din  in  16  CPU write data
cpu_ack  out  1  one-cycle completion pulse
rd_data  out  16  read data, shared by all requesters, valid with the owner's ack
owner  out  2  current owner code from the package
mem_addr  out  AW  memory address
mem_din  out  16  memory write data
mem_be  out  2  memory byte enables
mem_we  out  1  one-cycle write strobe
mem_rd  out  1  one-cycle read strobe
mem_dout  in  16  memory read data, valid RD_LAT cycles after mem_rd

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE; owner = OWN_NONE; all acks, mem_we and mem_rd = 0; mem_addr, mem_din, mem_be and rd_data = 0; starvation counter = 0.
  - Reset during ISSUE or WAIT abandons the access. No ack is ever produced for it, and nothing is replayed after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Evaluate requests. Pick order: vid; then cpu if starve_cnt == CPU_STARVE and cpu_req; then dsk; then cpu.
  - On a pick, latch address, we, be and din into registers, set owner, and go to ISSUE. With no request, stay in IDLE.
  - Fixed per-requester inputs: vid forces we=0, be=11. dsk forces be=11.
- ISSUE (1 cycle): drive mem_addr, mem_be and mem_din from the latches. Pulse mem_we if the access is a write, else mem_rd. Go to DONE for a write, WAIT for a read.
- WAIT (exactly RD_LAT cycles): in the last WAIT cycle, capture mem_dout into rd_data, then go to DONE.
- DONE (1 cycle): pulse the owner's ack, go to IDLE. owner returns to OWN_NONE in IDLE.
- Latency, with request sampled in IDLE at cycle 0:
  - Write: mem_we at cycle 1, ack at cycle 2.
  - Read: mem_rd at cycle 1, ack and valid rd_data at cycle RD_LAT+2.
  - Minimum request-to-request spacing is 3 cycles (write) or RD_LAT+3 cycles (read).
- Handshake:
  - Requester keeps req and its inputs stable until it samples ack.
  - Requester deasserts req on the same edge on which it samples ack.
  - The following IDLE cycle therefore never re-grants a finished access.
  - A req held high past that point is treated as a new request.
- Starvation counter (8-bit, saturating at CPU_STARVE):
  - Increments on each dsk grant while cpu_req = 1.
  - Clears on a cpu grant, or in any IDLE cycle with cpu_req = 0.
  - vid grants leave it unchanged.
- rd_data holds its last value until the next read capture; writes do not disturb it.
- A write with be = 00 still issues mem_we with mem_be = 00.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait with no timeout.
- Only one ack output is ever high in a cycle.

Decomposition:
- Package bk_mem_pkg holds:
  - owner codes OWN_NONE=0, OWN_VID=1, OWN_DSK=2, OWN_CPU=3;
  - the state enum arb_state_t {IDLE, ISSUE, WAIT, DONE};
  - width constant DW=16.
- One sub-module, mem_arb_pick: combinational priority/starvation selector. Inputs are the three reqs and the starve flag; output is the owner code. It is unit-testable in isolation.
- The FSM, latches, latency counter and starvation counter live in mem_arbiter.

Test Plan:
- All tests run with RD_LAT=2 and CPU_STARVE=4.
- CPU write, addr 0x00100, din 0x1234, be 11 -> cycle 1: mem_we=1, mem_addr=0x00100, mem_din=0x1234; cycle 2: cpu_ack=1; owner=3 during ISSUE and DONE.
- CPU read, addr 0x00200, memory returns 0xBEEF at cycle 3 -> mem_rd at cycle 1, cpu_ack at cycle 4 with rd_data=0xBEEF; no other ack fires.
- vid, dsk and cpu reads all raised in the same cycle -> grant order vid, dsk, cpu; acks at cycles 4, 9, 14.
- dsk issues back-to-back writes continuously while cpu_req is held -> after 4 dsk acks the CPU is granted next, then the counter reads 0 and disk resumes.
- reset pulsed during WAIT of a dsk read -> dsk_ack never asserts and all outputs return to 0. A cpu write raised after reset gives cpu_ack 2 cycles after it is sampled.
- cpu write with be=00 -> mem_we pulses with mem_be=00, cpu_ack at cycle 2, rd_data unchanged.
